led_bcd_scan_ctrl: RTL and testbench

//  Sequencing controller for the 8-digit multiplexed 7-segment display.

---
 rtl/led_pkg.sv | 33 +++
 rtl/bin2bcd_seq.sv | 60 ++++++
 rtl/led_bcd_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_led_bcd_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and elaboration helpers for the BCD scan display controller.
package led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   localparam int DIGITS_DEF = 8;
   localparam int BCD_W      = 4 * DIGITS_DEF;

   // ceil(log2(v)), valid for 1 <= v <= 2**31
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((32'd1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   function automatic int bcd_w(input int digits);
      return 4 * digits;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
module bin2bcd_seq
   import led_pkg::*;
#(
   parameter int DATA_W = 21,
   parameter int DIGITS = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic                  shift_i,
   input  logic [DATA_W-1:0]     data_i,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  done_o
);

   localparam int BW    = bcd_w(DIGITS);
   localparam int WW    = BW + DATA_W;
   localparam int CNT_W = clog2(DATA_W + 1);

   logic [WW-1:0]    work_q, work_d, adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // add 3 to every BCD nibble >= 5 before the shift
   always_comb begin
      adj = work_q;
      for (int i = 0; i < DIGITS; i++)
         if (work_q[DATA_W+4*i +: 4] >= 4'd5)
            adj[DATA_W+4*i +: 4] = work_q[DATA_W+4*i +: 4] + 4'd3;
   end

   // load / shift next-state; bit count stops at zero
   always_comb begin
      work_d = work_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         work_d = {{BW{1'b0}}, data_i};
         cnt_d  = CNT_W'(DATA_W - 1);
      end else if (shift_i) begin
         work_d = adj << 1;
         if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // work register and bit counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         work_q <= '0;
         cnt_q  <= '0;
      end else begin
         work_q <= work_d;
         cnt_q  <= cnt_d;
      end
   end

   // the shift issued while the count is zero is the last one
   assign done_o = shift_i && (cnt_q == '0);
   assign bcd_o  = work_q[WW-1 -: BW];

endmodule

// File: rtl/led_bcd_scan_ctrl.sv
// 8-digit 7-segment scan controller: valid/ready intake, sequential BCD
// conversion, atomic display register update, digit scan with leading-zero blanking.
module led_bcd_scan_ctrl
   import led_pkg::*;
#(
   parameter int DATA_W     = 21,
   parameter int DIGITS     = 8,
   parameter int SCAN_DIV_W = 15,
   parameter int BLANK_LZ   = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              busy_o,
   output logic              disp_update_o,
   output logic [DIGITS-1:0] digit_sel_o,
   output logic [3:0]        digit_val_o,
   output logic              digit_blank_o
);

   localparam int BW     = bcd_w(DIGITS);
   localparam int IDX_W  = clog2(DIGITS);
   localparam int SCAN_W = SCAN_DIV_W + IDX_W;

   // the largest input must fit in the available decimal digits
   if (((64'd1 << DATA_W) - 64'd1) >= pow10(DIGITS)) begin : g_range_chk
      $error("led_bcd_scan_ctrl: DATA_W too wide for DIGITS");
   end

   state_e            state_q, state_d;
   logic              load, shift, commit, conv_done;
   logic [BW-1:0]     bcd;
   logic [BW-1:0]     disp_q;
   logic              upd_q;
   logic [SCAN_W-1:0] scan_q;
   logic [IDX_W-1:0]  idx;
   logic [DIGITS-1:0] sel_d, sel_q;
   logic [3:0]        val_d, val_q;
   logic              blank_d, blank_q;

   bin2bcd_seq #(
      .DATA_W (DATA_W),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (load),
      .shift_i (shift),
      .data_i  (in_data_i),
      .bcd_o   (bcd),
      .done_o  (conv_done)
   );

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state and handshake/control outputs
   always_comb begin
      state_d    = state_q;
      in_ready_o = 1'b0;
      busy_o     = 1'b0;
      load       = 1'b0;
      shift      = 1'b0;
      commit     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               load    = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy_o = 1'b1;
            shift  = 1'b1;
            if (conv_done) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            busy_o  = 1'b1;
            commit  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // display register only changes in COMMIT so the scan never mixes values
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         disp_q <= '0;
         upd_q  <= 1'b0;
      end else begin
         upd_q <= commit;
         if (commit) disp_q <= bcd;
      end
   end

   // free-running scan counter, wraps silently
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) scan_q <= '0;
      else       scan_q <= scan_q + SCAN_W'(1);
   end

   assign idx = scan_q[SCAN_W-1 -: IDX_W];

   // select, value and blank for the current digit index
   always_comb begin
      sel_d      = '0;
      sel_d[idx] = 1'b1;
      val_d      = disp_q[{idx, 2'b00} +: 4];
      blank_d    = (BLANK_LZ != 0) && (idx != '0) && ((disp_q >> {idx, 2'b00}) == '0);
   end

   // register all three together so they change on the same edge
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sel_q   <= DIGITS'(1);
         val_q   <= '0;
         blank_q <= 1'b0;
      end else begin
         sel_q   <= sel_d;
         val_q   <= val_d;
         blank_q <= blank_d;
      end
   end

   assign disp_update_o = upd_q;
   assign digit_sel_o   = sel_q;
   assign digit_val_o   = val_q;
   assign digit_blank_o = blank_q;

endmodule

// File: tb/tb_led_bcd_scan_ctrl.sv
// Bench for led_bcd_scan_ctrl: decimal reference model checked every cycle,
// table-driven digit vectors, directed latency/back-to-back/reset sequences, random traffic.
module tb_led_bcd_scan_ctrl;

   localparam int DATA_W = 21;
   localparam int DIGITS = 8;
   localparam int SDIV   = 2;
   localparam int STEP   = 1 << SDIV;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready, busy, disp_update, digit_blank;
   logic [DIGITS-1:0] digit_sel;
   logic [3:0]        digit_val;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   led_bcd_scan_ctrl #(
      .DATA_W(DATA_W), .DIGITS(DIGITS), .SCAN_DIV_W(SDIV), .BLANK_LZ(1)
   ) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
      .in_ready_o(in_ready), .busy_o(busy), .disp_update_o(disp_update),
      .digit_sel_o(digit_sel), .digit_val_o(digit_val), .digit_blank_o(digit_blank)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned p10(input int n);
      int unsigned r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   // ---------------- reference model ----------------
   // Display shows a decimal number; each accepted value appears DATA_W+1 edges
   // after acceptance. Scan index is (edges since reset / STEP) mod DIGITS, seen one edge late.
   int unsigned m_k    = 0;
   int unsigned m_disp = 0;
   int unsigned m_pend = 0;
   int          m_rem  = 0;
   int          m_idx  = 0;
   bit          m_upd  = 1'b0;
   logic [7:0]  e_sel  = 8'h01;
   logic [3:0]  e_val  = 4'h0;
   logic        e_blank = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_k = 0; m_disp = 0; m_rem = 0; m_upd = 1'b0;
         e_sel = 8'h01; e_val = 4'h0; e_blank = 1'b0;
      end else begin
         m_idx   = int'((m_k / STEP) % DIGITS);
         e_sel   = 8'h01 << m_idx;
         e_val   = 4'((m_disp / p10(m_idx)) % 10);
         e_blank = (m_idx > 0) && ((m_disp / p10(m_idx)) == 0);
         m_k++;
         m_upd = 1'b0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               m_disp = m_pend;
               m_upd  = 1'b1;
            end
         end else if (in_valid) begin
            m_pend = in_data;
            m_rem  = DATA_W + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready",    32'(in_ready),    32'(m_rem == 0));
         chk("busy",        32'(busy),        32'(m_rem > 0));
         chk("disp_update", 32'(disp_update), 32'(m_upd));
         chk("digit_sel",   32'(digit_sel),   32'(e_sel));
         chk("digit_val",   32'(digit_val),   32'(e_val));
         chk("digit_blank", 32'(digit_blank), 32'(e_blank));
      end
   end

   // ---------------- helpers ----------------
   // hold in_valid until accepted; t_acc = transfer edge number
   task automatic send(input logic [DATA_W-1:0] v, output int t_acc);
      int budget;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v;
      budget   = 100;
      while (!in_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) chk("send_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      t_acc    = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_update(output int t_upd);
      int budget;
      budget = 100;
      t_upd  = -1;
      while (budget > 0) begin
         @(negedge clk);
         if (disp_update) begin
            t_upd = cyc;
            break;
         end
         budget--;
      end
      if (t_upd < 0) chk("update_timeout", 32'd1, 32'd0);
   endtask

   // watch one full scan rotation and collect what each digit shows
   task automatic scan(output logic [31:0] vals, output logic [7:0] bl);
      vals = '0;
      bl   = '0;
      repeat (DIGITS * STEP + 2) begin
         @(negedge clk);
         for (int i = 0; i < DIGITS; i++)
            if (digit_sel == (8'h01 << i)) begin
               vals[4*i +: 4] = digit_val;
               bl[i]          = digit_blank;
            end
      end
   endtask

   typedef struct {
      logic [DATA_W-1:0] val;
      logic [31:0]       digits;  // nibble i = digit i
      logic [7:0]        blank;
   } row_t;

   row_t tbl[7];

   initial begin
      int ta, tu, t2;
      logic [31:0] vals;
      logic [7:0]  bl;

      tbl[0] = '{21'd123456,  32'h00123456, 8'hC0};
      tbl[1] = '{21'd100205,  32'h00100205, 8'hC0};
      tbl[2] = '{21'd0,       32'h00000000, 8'hFE};
      tbl[3] = '{21'd2097151, 32'h02097151, 8'h80};
      tbl[4] = '{21'd1000000, 32'h01000000, 8'h80};
      tbl[5] = '{21'd7,       32'h00000007, 8'hFE};
      tbl[6] = '{21'd90000,   32'h00090000, 8'hE0};

      // reset state
      #2 rst = 1'b1;
      #1 chk_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_sel",   32'(digit_sel),   32'h01);
      chk("rst_ready", 32'(in_ready),    32'h1);
      chk("rst_upd",   32'(disp_update), 32'h0);
      rst = 1'b0;

      // table vectors, each with its acceptance-to-update latency
      for (int r = 0; r < 7; r++) begin
         send(tbl[r].val, ta);
         wait_update(tu);
         chk($sformatf("latency[%0d]", r), 32'(tu - ta), 32'(DATA_W + 1));
         @(negedge clk);
         scan(vals, bl);
         chk($sformatf("digits[%0d]", r), vals, tbl[r].digits);
         chk($sformatf("blank[%0d]", r),  32'(bl), 32'(tbl[r].blank));
      end

      // in_valid held high with a second value queued: back-to-back spacing
      send(21'd2097151, ta);
      in_valid = 1'b1;
      in_data  = 21'd424242;
      t2 = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1 t2 = cyc;
            break;
         end
      end
      in_valid = 1'b0;
      chk("b2b_spacing", 32'(t2 - ta), 32'(DATA_W + 2));
      wait_update(tu);
      @(negedge clk);
      scan(vals, bl);
      chk("b2b_digits", vals, 32'h00424242);

      // reset during SHIFT cycle 10: nothing commits, display returns to 0
      send(21'd654321, ta);
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_sel",  32'(digit_sel), 32'h01);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_ready", 32'(in_ready), 32'h1);
      t2 = 0;
      repeat (30) begin
         @(negedge clk);
         if (disp_update) t2++;
      end
      chk("no_commit_after_rst", 32'(t2), 32'h0);
      scan(vals, bl);
      chk("rst_digits", vals, 32'h0);
      chk("rst_blank",  32'(bl), 32'hFE);

      // random traffic with random gaps; the per-cycle model checks everything
      for (int n = 0; n < 40; n++) begin
         send(DATA_W'($urandom_range(0, (1 << DATA_W) - 1)), ta);
         repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      repeat (DATA_W + 5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      n_err++;
      $display("FAIL global_timeout: got running expected finished");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
